// File: rtl/ad80305_att_spi_resp.sv
// AD80305 attenuator SPI responder: serves AGC read requests and 1-dB inc/dec steps
// by running 24-bit mode-0 frames against the ATT register.
module ad80305_att_spi_resp #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [11:0] ATT_ADDR = 12'h10C,
  parameter logic [5:0]  ATT_MAX  = 6'd63,
  parameter int unsigned CS_GAP   = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_read_req,
  output logic       o_read_success,
  output logic [5:0] o_read_value,
  input  logic       i_inc_pulse,
  input  logic       i_dec_pulse,
  output logic [5:0] o_att_shadow,
  output logic       o_busy,
  output logic       o_spi_cs_n,
  output logic       o_spi_sclk,
  output logic       o_spi_sdo,
  input  logic       i_spi_sdi
);

  localparam int unsigned CNT_MAX = (2 * CLK_DIV > CS_GAP) ? 2 * CLK_DIV : CS_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        bit_q, bit_d;
  logic [23:0]       tx_q, tx_d;
  logic [5:0]        rx_q, rx_d;
  logic              rw_q, rw_d;
  logic [5:0]        target_q, target_d;
  logic              rd_pend_q, rd_pend_d;
  logic signed [6:0] pend_q, pend_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              success_q, success_d;
  logic [5:0]        value_q, value_d;
  logic [5:0]        shadow_q, shadow_d;

  logic              start;
  logic              clear_pend;
  logic              step_done;
  logic [23:0]       frame;
  logic signed [6:0] pend_tmp;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rw_q      <= 1'b0;
      target_q  <= '0;
      rd_pend_q <= 1'b0;
      pend_q    <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      success_q <= 1'b0;
      value_q   <= '0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rw_q      <= rw_d;
      target_q  <= target_d;
      rd_pend_q <= rd_pend_d;
      pend_q    <= pend_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      success_q <= success_d;
      value_q   <= value_d;
      shadow_q  <= shadow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rw_d       = rw_q;
    target_d   = target_q;
    rd_pend_d  = rd_pend_q | i_read_req;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    success_d  = 1'b0;
    value_d    = value_q;
    shadow_d   = shadow_q;
    start      = 1'b0;
    clear_pend = 1'b0;
    step_done  = 1'b0;
    frame      = '0;
    pend_tmp   = pend_q;

    case (state_q)
      S_IDLE: begin
        // A latched read always wins over a pending step.
        if (rd_pend_q) begin
          start     = 1'b1;
          rw_d      = 1'b1;
          rd_pend_d = i_read_req;
          frame     = {1'b1, 3'b000, ATT_ADDR, 8'h00};
        end else if (pend_q > 7'sd0) begin
          if (shadow_q == ATT_MAX) begin
            clear_pend = 1'b1;
          end else begin
            start    = 1'b1;
            rw_d     = 1'b0;
            target_d = shadow_q + 6'd1;
          end
        end else if (pend_q < 7'sd0) begin
          if (shadow_q == 6'd0) begin
            clear_pend = 1'b1;
          end else begin
            start    = 1'b1;
            rw_d     = 1'b0;
            target_d = shadow_q - 6'd1;
          end
        end
        if (start && !rw_d) begin
          frame = {1'b0, 3'b000, ATT_ADDR, 2'b00, target_d};
        end
        if (start) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          tx_d    = frame;
        end
      end

      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_SHIFT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == DIV_LAST) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[4:0], i_spi_sdi};
        end
        // Falling edge: advance to the next bit (sdo is always tx_q[23]).
        if (cnt_q == BIT_LAST) begin
          sclk_d = 1'b0;
          cnt_d  = '0;
          if (bit_q == 5'd23) begin
            state_d = S_HOLD;
            tx_d    = '0;
          end else begin
            bit_d = bit_q + 5'd1;
            tx_d  = {tx_q[22:0], 1'b0};
          end
        end
      end

      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          if (rw_q) begin
            value_d   = rx_q;
            shadow_d  = rx_q;
            success_d = 1'b1;
          end else begin
            shadow_d  = target_q;
            step_done = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Pending step count: retire or discard first, then apply this cycle's pulses.
    if (clear_pend) begin
      pend_tmp = '0;
    end else if (step_done) begin
      if (pend_q > 7'sd0) begin
        pend_tmp = pend_q - 7'sd1;
      end else if (pend_q < 7'sd0) begin
        pend_tmp = pend_q + 7'sd1;
      end
    end
    if (i_inc_pulse && !i_dec_pulse && (pend_tmp < 7'sd63)) begin
      pend_tmp = pend_tmp + 7'sd1;
    end else if (i_dec_pulse && !i_inc_pulse && (pend_tmp > -7'sd63)) begin
      pend_tmp = pend_tmp - 7'sd1;
    end
    pend_d = pend_tmp;
  end

  assign o_busy         = (state_q != S_IDLE);
  assign o_spi_cs_n     = cs_n_q;
  assign o_spi_sclk     = sclk_q;
  assign o_spi_sdo      = tx_q[23];
  assign o_read_success = success_q;
  assign o_read_value   = value_q;
  assign o_att_shadow   = shadow_q;

endmodule

// File: tb/tb_ad80305_att_spi_resp.sv
// Directed bench for ad80305_att_spi_resp: SPI slave model on the pins, expected frames
// and read results queued at stimulus time and compared as the DUT produces them.
module tb_ad80305_att_spi_resp;

  localparam int CS_LOW = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       read_req = 1'b0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       sdi;
  logic       read_success;
  logic [5:0] read_value;
  logic [5:0] att_shadow;
  logic       busy;
  logic       cs_n;
  logic       sclk;
  logic       sdo;

  always #5 clk = ~clk;

  ad80305_att_spi_resp dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_read_req     (read_req),
    .o_read_success (read_success),
    .o_read_value   (read_value),
    .i_inc_pulse    (inc),
    .i_dec_pulse    (dec),
    .o_att_shadow   (att_shadow),
    .o_busy         (busy),
    .o_spi_cs_n     (cs_n),
    .o_spi_sclk     (sclk),
    .o_spi_sdo      (sdo),
    .i_spi_sdi      (sdi)
  );

  // SPI slave model: captures MOSI on sclk rise, returns sdi_resp in the last 8 bits.
  logic [4:0]  mon_bit = '0;
  logic [23:0] cap = '0;
  int          lowcnt = 0;
  logic        cs_prev = 1'b1;
  logic        sclk_prev = 1'b0;
  logic [7:0]  sdi_resp = '0;
  logic [23:0] resp_word;

  assign resp_word = {16'h0000, sdi_resp};
  assign sdi = (mon_bit < 5'd24) ? resp_word[5'd23 - mon_bit] : 1'b0;

  logic [39:0] obs_frames[$];
  logic [11:0] obs_reads[$];
  logic [39:0] exp_frames[$];
  logic [11:0] exp_reads[$];
  int          f_idx = 0;
  int          r_idx = 0;
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_bit   <= '0;
      cap       <= '0;
      lowcnt    <= 0;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b0;
    end else begin
      if (!cs_n) begin
        lowcnt <= cs_prev ? 1 : lowcnt + 1;
        if (cs_prev) begin
          mon_bit <= '0;
          cap     <= '0;
        end else if (sclk && !sclk_prev) begin
          cap     <= {cap[22:0], sdo};
          mon_bit <= mon_bit + 5'd1;
        end
      end
      if (cs_n && !cs_prev) obs_frames.push_back({16'(lowcnt), cap});
      if (read_success) obs_reads.push_back({read_value, att_shadow});
      cs_prev   <= cs_n;
      sclk_prev <= sclk;
    end
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic r, input logic i, input logic d);
    @(negedge clk);
    read_req = r;
    inc      = i;
    dec      = d;
    @(negedge clk);
    read_req = 1'b0;
    inc      = 1'b0;
    dec      = 1'b0;
  endtask

  task automatic exp_frame(input logic rw, input logic [7:0] data);
    exp_frames.push_back({16'(CS_LOW), rw, 3'b000, 12'h10C, data});
  endtask

  task automatic exp_read(input logic [5:0] v);
    exp_reads.push_back({v, v});
  endtask

  task automatic wait_all();
    int target;
    target = f_idx + exp_frames.size();
    for (int i = 0; i < 6000; i++) begin
      if (obs_frames.size() >= target) break;
      @(negedge clk);
    end
    check("frame_wait", 40'(obs_frames.size() >= target), 40'(1));
    repeat (14) @(negedge clk);
  endtask

  task automatic drain();
    logic [39:0] ef;
    logic [11:0] er;
    while (exp_frames.size() > 0 && f_idx < obs_frames.size()) begin
      ef = exp_frames.pop_front();
      check("frame_bits", 40'(obs_frames[f_idx][23:0]), 40'(ef[23:0]));
      check("cs_low_cycles", 40'(obs_frames[f_idx][39:24]), 40'(ef[39:24]));
      f_idx++;
    end
    check("frames_missing", 40'(exp_frames.size()), 40'(0));
    check("frames_extra", 40'(obs_frames.size()), 40'(f_idx));
    while (exp_reads.size() > 0 && r_idx < obs_reads.size()) begin
      er = exp_reads.pop_front();
      check("read_value", 40'(obs_reads[r_idx][11:6]), 40'(er[11:6]));
      check("read_shadow", 40'(obs_reads[r_idx][5:0]), 40'(er[5:0]));
      r_idx++;
    end
    check("reads_missing", 40'(exp_reads.size()), 40'(0));
    check("reads_extra", 40'(obs_reads.size()), 40'(r_idx));
  endtask

  task automatic watch_idle(input int n, output logic saw);
    saw = 1'b0;
    repeat (n) begin
      @(negedge clk);
      saw = saw | busy;
    end
  endtask

  task automatic do_read(input logic [7:0] resp);
    sdi_resp = resp;
    exp_frame(1'b1, 8'h00);
    exp_read(resp[5:0]);
    pulse(1'b1, 1'b0, 1'b0);
    wait_all();
    drain();
  endtask

  initial begin
    logic saw;
    logic found;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs_n", 40'(cs_n), 40'(1));
    check("rst_sclk", 40'(sclk), 40'(0));
    check("rst_sdo", 40'(sdo), 40'(0));
    check("rst_busy", 40'(busy), 40'(0));
    check("rst_success", 40'(read_success), 40'(0));
    check("rst_value", 40'(read_value), 40'(0));
    check("rst_shadow", 40'(att_shadow), 40'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read returning 0x2A
    do_read(8'h2A);
    check("t1_value", 40'(read_value), 40'(6'h2A));
    check("t1_shadow", 40'(att_shadow), 40'(6'h2A));
    $display("t1 read 0x2A: value=%0h shadow=%0h", read_value, att_shadow);

    // Shadow 10, three back-to-back increments
    do_read(8'd10);
    exp_frame(1'b0, 8'h0B);
    exp_frame(1'b0, 8'h0C);
    exp_frame(1'b0, 8'h0D);
    @(negedge clk);
    inc = 1'b1;
    repeat (3) @(negedge clk);
    inc = 1'b0;
    wait_all();
    drain();
    check("t2_shadow", 40'(att_shadow), 40'(6'd13));
    check("t2_busy", 40'(busy), 40'(0));
    $display("t2 three incs: shadow=%0d", att_shadow);

    // inc and dec together: no frame
    pulse(1'b0, 1'b1, 1'b1);
    watch_idle(30, saw);
    check("t3_no_busy", 40'(saw), 40'(0));
    drain();
    $display("t3 inc+dec together: busy_seen=%0b", saw);

    // Lower bound: dec at 0 does nothing and leaves no residue
    do_read(8'h00);
    pulse(1'b0, 1'b0, 1'b1);
    watch_idle(30, saw);
    check("t4_dec_at_0_busy", 40'(saw), 40'(0));
    exp_frame(1'b0, 8'h01);
    pulse(1'b0, 1'b1, 1'b0);
    wait_all();
    drain();
    check("t4_shadow_1", 40'(att_shadow), 40'(6'd1));
    $display("t4 dec at 0 then inc: shadow=%0d", att_shadow);

    // Upper bound: inc at 63 does nothing and leaves no residue
    do_read(8'h3F);
    pulse(1'b0, 1'b1, 1'b0);
    watch_idle(30, saw);
    check("t4_inc_at_63_busy", 40'(saw), 40'(0));
    exp_frame(1'b0, 8'h3E);
    pulse(1'b0, 1'b0, 1'b1);
    wait_all();
    drain();
    check("t4_shadow_62", 40'(att_shadow), 40'(6'd62));
    $display("t4 inc at 63 then dec: shadow=%0d", att_shadow);

    // Read request during a write frame
    do_read(8'd5);
    exp_frame(1'b0, 8'h06);
    pulse(1'b0, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (!cs_n && mon_bit >= 5'd5 && mon_bit < 5'd24) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_in_write", 40'(found), 40'(1));
    sdi_resp = 8'h15;
    exp_frame(1'b1, 8'h00);
    exp_read(6'h15);
    pulse(1'b1, 1'b0, 1'b0);
    wait_all();
    drain();
    check("t5_shadow", 40'(att_shadow), 40'(6'h15));
    $display("t5 read during write: shadow=%0h", att_shadow);

    // Reset mid-frame at bit 10, with a latched read and pending step queued
    sdi_resp = 8'h33;
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (!cs_n && mon_bit == 5'd11) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_reach_bit10", 40'(found), 40'(1));
    #2;
    check("t6_sclk_high_before", 40'(sclk), 40'(1));
    rst_n = 1'b0;
    #1;
    check("t6_cs_n_async", 40'(cs_n), 40'(1));
    check("t6_sclk_async", 40'(sclk), 40'(0));
    check("t6_busy_async", 40'(busy), 40'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    watch_idle(60, saw);
    check("t6_no_busy_after", 40'(saw), 40'(0));
    check("t6_no_frames", 40'(obs_frames.size()), 40'(f_idx));
    check("t6_no_success", 40'(obs_reads.size()), 40'(r_idx));
    check("t6_shadow", 40'(att_shadow), 40'(0));
    check("t6_value", 40'(read_value), 40'(0));
    $display("t6 reset mid-frame: busy_seen=%0b shadow=%0d", saw, att_shadow);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
